// File: rtl/mesh_traffic_sequencer.sv
// Run controller for the loader-driven XY mesh test harness.
// Queues host commands into per-loader FIFOs, launches a run, waits for the
// loaders to drain (bounded by a timeout) and then streams every PMU counter
// back to the host, one register at a time.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   LOAD      | accept host commands, push them to loader FIFOs; wait for run
//   START     | global start pulse, FIFO occupancy and run timer re-armed
//   SETTLE    | two fixed cycles so the loaders can drop idle
//   WAIT      | wait for all loaders idle or for the run timer to expire
//   DUMP_ADDR | present register address to the selected PMU
//   DUMP_OUT  | hold captured counter on res_* until the host takes it
//   DONE      | one-cycle done pulse, run finished
//
// N must be at least 2. The PMU register files are expected to return read
// data combinationally from pmu_addr_o within the same cycle.

module mesh_traffic_sequencer #(
   parameter int N          = 16,
   parameter int FIFO_DEPTH = 64,
   parameter int PMU_REGS   = 32,
   parameter int TIMEOUT_W  = 20
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         cmd_valid_i,
   output logic                         cmd_ready_o,
   input  logic [$clog2(N)-1:0]         cmd_loader_i,
   input  logic [4:0]                   cmd_id_i,
   input  logic                         cmd_write_i,
   input  logic [7:0]                   cmd_axlen_i,
   input  logic                         cmd_resp_wait_i,
   input  logic                         run_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         timeout_o,
   output logic                         res_valid_o,
   input  logic                         res_ready_i,
   output logic [$clog2(N)-1:0]         res_loader_o,
   output logic [4:0]                   res_reg_o,
   output logic [31:0]                  res_data_o,
   output logic [N-1:0]                 resp_wait_o,
   output logic [N-1:0][4:0]            id_o,
   output logic [N-1:0]                 write_o,
   output logic [N-1:0][7:0]            axlen_o,
   output logic [N-1:0]                 fifo_push_o,
   output logic                         start_o,
   input  logic [N-1:0]                 idle_i,
   output logic [N-1:0][4:0]            pmu_addr_o,
   input  logic [N-1:0][31:0]           pmu_data_i
);

   localparam int LW = $clog2(N);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [4:0]    LAST_REG    = 5'(PMU_REGS - 1);
   localparam logic [LW-1:0] LAST_LOADER = LW'(N - 1);

   typedef enum logic [2:0] {
      LOAD,
      START,
      SETTLE,
      WAIT,
      DUMP_ADDR,
      DUMP_OUT,
      DONE
   } state_t;

   state_t                state;
   logic [CW-1:0]         cnt [N];
   logic [TIMEOUT_W-1:0]  timer;
   logic                  settle_cnt;
   logic [LW-1:0]         dump_l;
   logic [4:0]            dump_r;

   logic                  target_full;
   logic [31:0]           sel_data;
   logic [LW-1:0]         next_l;
   logic [4:0]            next_r;
   logic                  last_item;

   // Command acceptance: only in LOAD, never alongside run_i, never into a full FIFO.
   // Indices beyond N-1 never match a counter, so they are always accepted and dropped.
   always_comb begin
      target_full = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (cmd_loader_i == LW'(i) && cnt[i] == CW'(FIFO_DEPTH)) begin
            target_full = 1'b1;
         end
      end
      cmd_ready_o = (state == LOAD) && !target_full && !run_i;
   end

   // Dump cursor: read-data select and the loader/register that follows the current one.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (dump_l == LW'(i)) begin
            sel_data = pmu_data_i[i];
         end
      end
      last_item = (dump_l == LAST_LOADER) && (dump_r == LAST_REG);
      if (dump_r == LAST_REG) begin
         next_r = '0;
         next_l = dump_l + LW'(1);
      end else begin
         next_r = dump_r + 5'd1;
         next_l = dump_l;
      end
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state        <= LOAD;
         timer        <= '0;
         settle_cnt   <= 1'b0;
         dump_l       <= '0;
         dump_r       <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         timeout_o    <= 1'b0;
         start_o      <= 1'b0;
         res_valid_o  <= 1'b0;
         res_loader_o <= '0;
         res_reg_o    <= '0;
         res_data_o   <= '0;
         fifo_push_o  <= '0;
         resp_wait_o  <= '0;
         id_o         <= '0;
         write_o      <= '0;
         axlen_o      <= '0;
         pmu_addr_o   <= '0;
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         fifo_push_o <= '0;
         start_o     <= 1'b0;
         done_o      <= 1'b0;

         case (state)
            LOAD: begin
               if (run_i) begin
                  timeout_o <= 1'b0;
                  busy_o    <= 1'b1;
                  start_o   <= 1'b1;
                  state     <= START;
               end else if (cmd_valid_i && cmd_ready_o) begin
                  for (int i = 0; i < N; i++) begin
                     if (cmd_loader_i == LW'(i)) begin
                        fifo_push_o[i] <= 1'b1;
                        id_o[i]        <= cmd_id_i;
                        write_o[i]     <= cmd_write_i;
                        axlen_o[i]     <= cmd_axlen_i;
                        resp_wait_o[i] <= cmd_resp_wait_i;
                        cnt[i]         <= cnt[i] + CW'(1);
                     end
                  end
               end
            end

            START: begin
               for (int i = 0; i < N; i++) begin
                  cnt[i] <= '0;
               end
               // Down-counter: terminal count 1 is reached after 2**TIMEOUT_W-1 WAIT cycles.
               timer      <= '1;
               settle_cnt <= 1'b0;
               state      <= SETTLE;
            end

            SETTLE: begin
               if (settle_cnt) begin
                  state <= WAIT;
               end else begin
                  settle_cnt <= 1'b1;
               end
            end

            WAIT: begin
               if (&idle_i || timer == TIMEOUT_W'(1)) begin
                  if (!(&idle_i)) begin
                     timeout_o <= 1'b1;
                  end
                  dump_l     <= '0;
                  dump_r     <= '0;
                  pmu_addr_o <= '0;
                  state      <= DUMP_ADDR;
               end else begin
                  timer <= timer - TIMEOUT_W'(1);
               end
            end

            DUMP_ADDR: begin
               res_data_o   <= sel_data;
               res_loader_o <= dump_l;
               res_reg_o    <= dump_r;
               res_valid_o  <= 1'b1;
               state        <= DUMP_OUT;
            end

            DUMP_OUT: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  if (last_item) begin
                     pmu_addr_o <= '0;
                     busy_o     <= 1'b0;
                     done_o     <= 1'b1;
                     state      <= DONE;
                  end else begin
                     dump_l <= next_l;
                     dump_r <= next_r;
                     for (int i = 0; i < N; i++) begin
                        pmu_addr_o[i] <= (next_l == LW'(i)) ? next_r : 5'd0;
                     end
                     state <= DUMP_ADDR;
                  end
               end
            end

            DONE: begin
               state <= LOAD;
            end

            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule
